hazard_ctrl: RTL and testbench

Pipeline hazard controller that sits directly upstream of the IF/ID latch and drives its `Data_stall` and `flush` inputs. It decodes the instruction currently held in ID and tracks, in a 3-deep destination-register scoreboard, which registers are still in flight in EX/MEM/WB. It also runs a flush counter that holds the front end for a fixed number of cycles after every branch or jump. No forwarding exists in this pipeline, so every RAW dependence resolves by stalling.

---
 rtl/riscv_pkg.sv | 36 +++
 rtl/reg_use_decode.sv | 77 +++++++
 rtl/hazard_ctrl.sv | 94 +++++++++
 tb/tb_hazard_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and instruction field helpers.
//   OP_*      : 7-bit major opcodes used by the hazard logic
//   NOP_FLUSH : bubble injected into IF/ID during a branch/jump flush
//   get_*     : field extraction for opcode, rd, rs1, rs2
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // lw x0,0(x0): rd = x0, so it neither writes nor branches.
   localparam logic [31:0] NOP_FLUSH = 32'h0000_2003;

   function automatic logic [6:0] get_opcode(input logic [31:0] ir);
      return ir[6:0];
   endfunction

   function automatic logic [4:0] get_rd(input logic [31:0] ir);
      return ir[11:7];
   endfunction

   function automatic logic [4:0] get_rs1(input logic [31:0] ir);
      return ir[19:15];
   endfunction

   function automatic logic [4:0] get_rs2(input logic [31:0] ir);
      return ir[24:20];
   endfunction

endpackage

// File: rtl/reg_use_decode.sv
// Combinational register-usage decode of one RV32I instruction.
//   instr    in  32  instruction word
//   rs1/rs2  out 5   source register fields
//   rd       out 5   destination register field
//   rs1_used out 1   instruction reads rs1 and rs1 != x0
//   rs2_used out 1   instruction reads rs2 and rs2 != x0
//   rd_wr    out 1   instruction writes rd and rd != x0
//   is_bj    out 1   branch, jal or jalr
module reg_use_decode
   import riscv_pkg::*;
(
   input  logic [31:0] instr,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic        rs1_used,
   output logic        rs2_used,
   output logic        rd_wr,
   output logic        is_bj
);

   logic rs1_rd;
   logic rs2_rd;
   logic rd_we;

   // funct3/funct7 do not affect register usage.
   logic unused_fields;
   assign unused_fields = ^{instr[31:25], instr[14:12]};

   always_comb begin
      rs1    = get_rs1(instr);
      rs2    = get_rs2(instr);
      rd     = get_rd(instr);
      rs1_rd = 1'b0;
      rs2_rd = 1'b0;
      rd_we  = 1'b0;
      is_bj  = 1'b0;
      case (get_opcode(instr))
         OP_R: begin
            rs1_rd = 1'b1;
            rs2_rd = 1'b1;
            rd_we  = 1'b1;
         end
         OP_IMM, OP_LOAD: begin
            rs1_rd = 1'b1;
            rd_we  = 1'b1;
         end
         OP_STORE: begin
            rs1_rd = 1'b1;
            rs2_rd = 1'b1;
         end
         OP_BRANCH: begin
            rs1_rd = 1'b1;
            rs2_rd = 1'b1;
            is_bj  = 1'b1;
         end
         OP_JAL: begin
            rd_we  = 1'b1;
            is_bj  = 1'b1;
         end
         OP_JALR: begin
            rs1_rd = 1'b1;
            rd_we  = 1'b1;
            is_bj  = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            rd_we  = 1'b1;
         end
         default: ;
      endcase
      // x0 is hardwired: reading it never depends on anything, writing it is a no-op.
      rs1_used = rs1_rd && (rs1 != 5'd0);
      rs2_used = rs2_rd && (rs2 != 5'd0);
      rd_wr    = rd_we && (rd != 5'd0);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller feeding the IF/ID latch (no forwarding path).
//   clk        in  1   pipeline clock
//   rst        in  1   synchronous active-high reset
//   en         in  1   global enable; low freezes scoreboard and flush counter
//   ID_IR      in  32  instruction currently in ID
//   data_stall out 1   RAW hazard against an in-flight rd
//   bj_stall   out 1   branch/jump flush window
//   pc_hold    out 1   data_stall | bj_stall
//   ex_bubble  out 1   ID/EX loads a NOP (same as data_stall)
module hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 3,
   parameter bit          CHECK_WB     = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] ID_IR,
   output logic        data_stall,
   output logic        bj_stall,
   output logic        pc_hold,
   output logic        ex_bubble
);

   localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

   logic [4:0] rs1, rs2, rd;
   logic       rs1_used, rs2_used, rd_wr, is_bj;

   logic [4:0] ex_rd_q, ex_rd_d;
   logic [4:0] mem_rd_q, mem_rd_d;
   logic [4:0] wb_rd_q, wb_rd_d;
   logic [2:0] cnt_q, cnt_d;

   logic rs1_hit, rs2_hit, bj_detect;

   reg_use_decode u_dec (
      .instr    (ID_IR),
      .rs1      (rs1),
      .rs2      (rs2),
      .rd       (rd),
      .rs1_used (rs1_used),
      .rs2_used (rs2_used),
      .rd_wr    (rd_wr),
      .is_bj    (is_bj)
   );

   always_comb begin
      // Empty slots hold 0; since a used rs is never x0 they cannot match.
      rs1_hit = rs1_used && ((rs1 == ex_rd_q) || (rs1 == mem_rd_q) ||
                             (CHECK_WB && (rs1 == wb_rd_q)));
      rs2_hit = rs2_used && ((rs2 == ex_rd_q) || (rs2 == mem_rd_q) ||
                             (CHECK_WB && (rs2 == wb_rd_q)));
      data_stall = rs1_hit || rs2_hit;

      // A branch waiting on its operands must not start the flush yet.
      bj_detect = is_bj && !data_stall && (cnt_q == 3'd0);
      bj_stall  = bj_detect || (cnt_q != 3'd0);
      pc_hold   = data_stall || bj_stall;
      ex_bubble = data_stall;

      ex_rd_d  = ex_rd_q;
      mem_rd_d = mem_rd_q;
      wb_rd_d  = wb_rd_q;
      cnt_d    = cnt_q;
      if (en) begin
         wb_rd_d  = mem_rd_q;
         mem_rd_d = ex_rd_q;
         // The branch itself proceeds into EX, so jal/jalr rd gets tracked.
         ex_rd_d  = (rd_wr && !data_stall) ? rd : 5'd0;
         if (bj_detect) begin
            cnt_d = CNT_LOAD;
         end else if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_rd_q  <= 5'd0;
         mem_rd_q <= 5'd0;
         wb_rd_q  <= 5'd0;
         cnt_q    <= 3'd0;
      end else begin
         ex_rd_q  <= ex_rd_d;
         mem_rd_q <= mem_rd_d;
         wb_rd_q  <= wb_rd_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (FLUSH_CYCLES = 3, CHECK_WB = 0).
module tb_hazard_ctrl;

   localparam logic [31:0] NOP      = 32'h0000_2003;
   localparam logic [31:0] ADDI_X5  = 32'h0010_0293; // addi x5,x0,1
   localparam logic [31:0] ADD_X6   = 32'h0052_8333; // add x6,x5,x5
   localparam logic [31:0] ADDI_X0  = 32'h0010_0013; // addi x0,x0,1
   localparam logic [31:0] ADD_X1   = 32'h0000_00B3; // add x1,x0,x0
   localparam logic [31:0] BEQ_X1X2 = 32'h0020_8463; // beq x1,x2,8
   localparam logic [31:0] ADDI_X1  = 32'h0040_0093; // addi x1,x0,4
   localparam logic [31:0] BEQ_X1X0 = 32'h0000_8463; // beq x1,x0,8
   localparam logic [31:0] JAL_X1   = 32'h0080_00EF; // jal x1,8
   localparam logic [31:0] ADDI_X7  = 32'h0010_0393; // addi x7,x0,1
   localparam logic [31:0] SW_X7    = 32'h0071_2023; // sw x7,0(x2)
   localparam logic [31:0] LUI_X3   = 32'h0002_81B7; // lui x3,0x28 (rs1 field = 5)

   typedef struct {
      logic [31:0] ir;
      logic        en;
      logic        rst;
      logic        ds;
      logic        bj;
   } step_t;

   logic        clk;
   logic        rst;
   logic        en;
   logic [31:0] ID_IR;
   logic        data_stall;
   logic        bj_stall;
   logic        pc_hold;
   logic        ex_bubble;

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_q[$];

   hazard_ctrl #(.FLUSH_CYCLES(3), .CHECK_WB(1'b0)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .ID_IR      (ID_IR),
      .data_stall (data_stall),
      .bj_stall   (bj_stall),
      .pc_hold    (pc_hold),
      .ex_bubble  (ex_bubble)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic step_t mk(logic [31:0] ir, logic e, logic r, logic ds, logic bj);
      step_t s;
      s.ir = ir; s.en = e; s.rst = r; s.ds = ds; s.bj = bj;
      return s;
   endfunction

   // Drive one cycle at the falling edge and queue the expected outputs.
   task automatic apply(input step_t s);
      @(negedge clk);
      ID_IR = s.ir;
      en    = s.en;
      rst   = s.rst;
      exp_q.push_back({s.ds, s.bj, s.ds | s.bj, s.ds});
      #1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1; en = 1'b1; ID_IR = 32'h0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({data_stall, bj_stall, pc_hold, ex_bubble} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs got %b want 0000", {data_stall, bj_stall, pc_hold, ex_bubble});
      end
      checks++;
      if (dut.cnt_q !== 3'd0) begin
         errors++;
         $display("FAIL reset_cnt got %0d want 0", dut.cnt_q);
      end
      checks++;
      if ({dut.ex_rd_q, dut.mem_rd_q, dut.wb_rd_q} !== 15'd0) begin
         errors++;
         $display("FAIL reset_sb got %0d/%0d/%0d want 0/0/0", dut.ex_rd_q, dut.mem_rd_q, dut.wb_rd_q);
      end
   endtask

   task automatic test_raw;
      step_t s[$];
      logic [3:0] e;
      s.push_back(mk(ADDI_X5, 1, 0, 0, 0));
      s.push_back(mk(ADD_X6,  1, 0, 1, 0));
      s.push_back(mk(ADD_X6,  1, 0, 1, 0));
      s.push_back(mk(ADD_X6,  1, 0, 0, 0));
      s.push_back(mk(NOP,     1, 0, 0, 0));
      s.push_back(mk(NOP,     1, 0, 0, 0));
      s.push_back(mk(NOP,     1, 0, 0, 0));
      foreach (s[i]) begin
         apply(s[i]);
         e = exp_q.pop_front();
         checks++;
         if ({data_stall, bj_stall, pc_hold, ex_bubble} !== e) begin
            errors++;
            $display("FAIL raw step %0d got %b want %b", i, {data_stall, bj_stall, pc_hold, ex_bubble}, e);
         end
         if (i == 4) begin
            checks++;
            if (dut.ex_rd_q !== 5'd6) begin
               errors++;
               $display("FAIL raw_issue ex_rd got %0d want 6", dut.ex_rd_q);
            end
         end
      end
   endtask

   task automatic test_x0;
      step_t s[$];
      logic [3:0] e;
      s.push_back(mk(ADDI_X0, 1, 0, 0, 0));
      s.push_back(mk(ADD_X1,  1, 0, 0, 0));
      s.push_back(mk(ADD_X1,  1, 0, 0, 0));
      s.push_back(mk(NOP,     1, 0, 0, 0));
      s.push_back(mk(NOP,     1, 0, 0, 0));
      s.push_back(mk(NOP,     1, 0, 0, 0));
      foreach (s[i]) begin
         apply(s[i]);
         e = exp_q.pop_front();
         checks++;
         if ({data_stall, bj_stall, pc_hold, ex_bubble} !== e) begin
            errors++;
            $display("FAIL x0 step %0d got %b want %b", i, {data_stall, bj_stall, pc_hold, ex_bubble}, e);
         end
         if (i == 1) begin
            checks++;
            if (dut.ex_rd_q !== 5'd0) begin
               errors++;
               $display("FAIL x0_write ex_rd got %0d want 0", dut.ex_rd_q);
            end
         end
      end
   endtask

   task automatic test_rs2_and_lui;
      step_t s[$];
      logic [3:0] e;
      s.push_back(mk(ADDI_X7, 1, 0, 0, 0));
      s.push_back(mk(SW_X7,   1, 0, 1, 0));
      s.push_back(mk(SW_X7,   1, 0, 1, 0));
      s.push_back(mk(SW_X7,   1, 0, 0, 0));
      s.push_back(mk(NOP,     1, 0, 0, 0));
      s.push_back(mk(NOP,     1, 0, 0, 0));
      s.push_back(mk(ADDI_X5, 1, 0, 0, 0));
      s.push_back(mk(LUI_X3,  1, 0, 0, 0));
      s.push_back(mk(NOP,     1, 0, 0, 0));
      s.push_back(mk(NOP,     1, 0, 0, 0));
      s.push_back(mk(NOP,     1, 0, 0, 0));
      foreach (s[i]) begin
         apply(s[i]);
         e = exp_q.pop_front();
         checks++;
         if ({data_stall, bj_stall, pc_hold, ex_bubble} !== e) begin
            errors++;
            $display("FAIL rs2_lui step %0d got %b want %b", i, {data_stall, bj_stall, pc_hold, ex_bubble}, e);
         end
         if (i == 8) begin
            checks++;
            if (dut.ex_rd_q !== 5'd3) begin
               errors++;
               $display("FAIL lui_write ex_rd got %0d want 3", dut.ex_rd_q);
            end
         end
      end
   endtask

   task automatic test_branch_flush;
      step_t s[$];
      logic [3:0] e;
      logic [2:0] cnt_exp[5] = '{3'd0, 3'd2, 3'd1, 3'd0, 3'd0};
      s.push_back(mk(BEQ_X1X2, 1, 0, 0, 1));
      s.push_back(mk(NOP,      1, 0, 0, 1));
      s.push_back(mk(NOP,      1, 0, 0, 1));
      s.push_back(mk(NOP,      1, 0, 0, 0));
      s.push_back(mk(NOP,      1, 0, 0, 0));
      foreach (s[i]) begin
         apply(s[i]);
         e = exp_q.pop_front();
         checks++;
         if ({data_stall, bj_stall, pc_hold, ex_bubble} !== e) begin
            errors++;
            $display("FAIL branch step %0d got %b want %b", i, {data_stall, bj_stall, pc_hold, ex_bubble}, e);
         end
         checks++;
         if (dut.cnt_q !== cnt_exp[i]) begin
            errors++;
            $display("FAIL branch_cnt step %0d got %0d want %0d", i, dut.cnt_q, cnt_exp[i]);
         end
         if (i == 1) begin
            checks++;
            if (dut.ex_rd_q !== 5'd0) begin
               errors++;
               $display("FAIL branch_rd ex_rd got %0d want 0", dut.ex_rd_q);
            end
         end
      end
   endtask

   task automatic test_branch_hazard;
      step_t s[$];
      logic [3:0] e;
      s.push_back(mk(ADDI_X1,  1, 0, 0, 0));
      s.push_back(mk(BEQ_X1X0, 1, 0, 1, 0));
      s.push_back(mk(BEQ_X1X0, 1, 0, 1, 0));
      s.push_back(mk(BEQ_X1X0, 1, 0, 0, 1));
      s.push_back(mk(NOP,      1, 0, 0, 1));
      s.push_back(mk(NOP,      1, 0, 0, 1));
      s.push_back(mk(NOP,      1, 0, 0, 0));
      foreach (s[i]) begin
         apply(s[i]);
         e = exp_q.pop_front();
         checks++;
         if ({data_stall, bj_stall, pc_hold, ex_bubble} !== e) begin
            errors++;
            $display("FAIL br_hazard step %0d got %b want %b", i, {data_stall, bj_stall, pc_hold, ex_bubble}, e);
         end
      end
   endtask

   task automatic test_jal;
      step_t s[$];
      logic [3:0] e;
      s.push_back(mk(JAL_X1, 1, 0, 0, 1));
      s.push_back(mk(NOP,    1, 0, 0, 1));
      s.push_back(mk(NOP,    1, 0, 0, 1));
      s.push_back(mk(NOP,    1, 0, 0, 0));
      s.push_back(mk(NOP,    1, 0, 0, 0));
      s.push_back(mk(NOP,    1, 0, 0, 0));
      foreach (s[i]) begin
         apply(s[i]);
         e = exp_q.pop_front();
         checks++;
         if ({data_stall, bj_stall, pc_hold, ex_bubble} !== e) begin
            errors++;
            $display("FAIL jal step %0d got %b want %b", i, {data_stall, bj_stall, pc_hold, ex_bubble}, e);
         end
         if (i == 1) begin
            checks++;
            if (dut.ex_rd_q !== 5'd1) begin
               errors++;
               $display("FAIL jal_rd ex_rd got %0d want 1", dut.ex_rd_q);
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      step_t s[$];
      logic [3:0] e;
      s.push_back(mk(BEQ_X1X2, 1, 0, 0, 1));
      s.push_back(mk(NOP,      1, 0, 0, 1));
      s.push_back(mk(NOP,      1, 1, 0, 1));
      s.push_back(mk(NOP,      1, 0, 0, 0));
      s.push_back(mk(ADDI_X5,  1, 0, 0, 0));
      s.push_back(mk(ADD_X6,   1, 1, 1, 0));
      s.push_back(mk(ADD_X6,   1, 0, 0, 0));
      s.push_back(mk(NOP,      1, 0, 0, 0));
      s.push_back(mk(NOP,      1, 0, 0, 0));
      s.push_back(mk(NOP,      1, 0, 0, 0));
      foreach (s[i]) begin
         apply(s[i]);
         e = exp_q.pop_front();
         checks++;
         if ({data_stall, bj_stall, pc_hold, ex_bubble} !== e) begin
            errors++;
            $display("FAIL rst_mid step %0d got %b want %b", i, {data_stall, bj_stall, pc_hold, ex_bubble}, e);
         end
         if (i == 2 || i == 3) begin
            checks++;
            if (dut.cnt_q !== ((i == 2) ? 3'd1 : 3'd0)) begin
               errors++;
               $display("FAIL rst_mid_cnt step %0d got %0d want %0d", i, dut.cnt_q, (i == 2) ? 1 : 0);
            end
         end
         if (i == 6) begin
            checks++;
            if ({dut.ex_rd_q, dut.mem_rd_q} !== 10'd0) begin
               errors++;
               $display("FAIL rst_mid_sb got %0d/%0d want 0/0", dut.ex_rd_q, dut.mem_rd_q);
            end
         end
      end
   endtask

   task automatic test_en_hold;
      step_t s[$];
      logic [3:0] e;
      s.push_back(mk(ADDI_X5,  1, 0, 0, 0));
      s.push_back(mk(ADD_X6,   0, 0, 1, 0));
      s.push_back(mk(ADD_X6,   0, 0, 1, 0));
      s.push_back(mk(ADD_X6,   1, 0, 1, 0));
      s.push_back(mk(ADD_X6,   1, 0, 1, 0));
      s.push_back(mk(ADD_X6,   1, 0, 0, 0));
      s.push_back(mk(NOP,      1, 0, 0, 0));
      s.push_back(mk(NOP,      1, 0, 0, 0));
      s.push_back(mk(NOP,      1, 0, 0, 0));
      s.push_back(mk(BEQ_X1X2, 1, 0, 0, 1));
      s.push_back(mk(NOP,      0, 0, 0, 1));
      s.push_back(mk(NOP,      0, 0, 0, 1));
      s.push_back(mk(NOP,      1, 0, 0, 1));
      s.push_back(mk(NOP,      1, 0, 0, 1));
      s.push_back(mk(NOP,      1, 0, 0, 0));
      foreach (s[i]) begin
         apply(s[i]);
         e = exp_q.pop_front();
         checks++;
         if ({data_stall, bj_stall, pc_hold, ex_bubble} !== e) begin
            errors++;
            $display("FAIL en_hold step %0d got %b want %b", i, {data_stall, bj_stall, pc_hold, ex_bubble}, e);
         end
         if (i == 2) begin
            checks++;
            if ({dut.ex_rd_q, dut.mem_rd_q} !== {5'd5, 5'd0}) begin
               errors++;
               $display("FAIL en_hold_sb got %0d/%0d want 5/0", dut.ex_rd_q, dut.mem_rd_q);
            end
         end
         if (i == 6) begin
            checks++;
            if (dut.ex_rd_q !== 5'd6) begin
               errors++;
               $display("FAIL en_hold_issue ex_rd got %0d want 6", dut.ex_rd_q);
            end
         end
         if (i == 10 || i == 11) begin
            checks++;
            if (dut.cnt_q !== 3'd2) begin
               errors++;
               $display("FAIL en_hold_cnt step %0d got %0d want 2", i, dut.cnt_q);
            end
         end
      end
   endtask

   initial begin
      rst   = 1'b1;
      en    = 1'b1;
      ID_IR = 32'h0;
      test_reset();
      test_raw();
      test_x0();
      test_rs2_and_lui();
      test_branch_flush();
      test_branch_hazard();
      test_jal();
      test_reset_mid();
      test_en_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
